// File: rtl/adder_acc_sched_pkg.sv
// Shared definitions for the accumulation-adder scheduler.
//   - adder mode encodings driven on adder_mode
//   - scheduler FSM state encoding (also visible on the dbg_state port)
package adder_acc_sched_pkg;

  // Adder operating modes
  localparam logic [1:0] MODE_SUM  = 2'd0;  // Data_in1+2+3
  localparam logic [1:0] MODE_PSUM = 2'd1;  // sum + psum
  localparam logic [1:0] MODE_BIAS = 2'd2;  // sum + psum + bias (final)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/adder_acc_sched_acc_loop_cnt.sv
// Nested channel-group / pixel counter (acc_loop_cnt) for the scheduler.
// p runs 0..P-1 within a group; when p wraps, g advances 0..N-1.
// Ports:
//   clk, rst      clock, async active-high reset
//   clear_i       restart both counters at 0 (new pass)
//   adv_i         advance by one beat
//   groups_i      N (latched by the parent)
//   pixels_i      P (latched by the parent)
//   g_o, p_o      current group / pixel index
//   last_g_o      g == N-1
//   last_beat_o   g == N-1 and p == P-1
module adder_acc_sched_acc_loop_cnt
  import adder_acc_sched_pkg::*;
#(
  parameter int GROUP_W = 8,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               adv_i,
  input  logic [GROUP_W-1:0] groups_i,
  input  logic [ADDR_W-1:0]  pixels_i,
  output logic [GROUP_W-1:0] g_o,
  output logic [ADDR_W-1:0]  p_o,
  output logic               last_g_o,
  output logic               last_beat_o
);

  localparam logic [GROUP_W-1:0] ONE_G = GROUP_W'(1);
  localparam logic [ADDR_W-1:0]  ONE_P = ADDR_W'(1);

  logic [GROUP_W-1:0] g_q, g_d;
  logic [ADDR_W-1:0]  p_q, p_d;
  logic               last_p;
  logic               last_g;

  // Wrap is detected against P-1 rather than counter overflow, so
  // P = 2^ADDR_W-1 works with an ADDR_W-bit counter.
  assign last_p = (p_q == (pixels_i - ONE_P));
  assign last_g = (g_q == (groups_i - ONE_G));

  always_comb begin
    g_d = g_q;
    p_d = p_q;
    if (clear_i) begin
      g_d = '0;
      p_d = '0;
    end else if (adv_i) begin
      if (last_p) begin
        p_d = '0;
        g_d = last_g ? '0 : (g_q + ONE_G);
      end else begin
        p_d = p_q + ONE_P;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q <= '0;
      p_q <= '0;
    end else begin
      g_q <= g_d;
      p_q <= p_d;
    end
  end

  assign g_o         = g_q;
  assign p_o         = p_q;
  assign last_g_o    = last_g;
  assign last_beat_o = last_g & last_p;

endmodule

// File: rtl/adder_acc_sched.sv
// Scheduler for the three-input accumulation adder over one layer pass.
// For each output pixel it selects the adder mode per channel group:
// first group = plain sum (written to psum), middle groups = +psum
// (written back), last group = +psum+bias (emitted downstream).
//
// Handshakes: a PE beat transfers when pe_valid & pe_ready. A final
// result transfers when out_valid & out_ready; out_valid, adder_mode
// and psum_wr_addr stay stable until that happens.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   start, cfg_groups/pixels  pass start pulse and N/P configuration
//   pe_valid / pe_ready       PE row-sum handshake
//   out_ready / out_valid     downstream handshake for final results
//   s1_en                     stage-1 datapath register enable
//   adder_mode, psum_zero     adder controls (from stage-1 register)
//   psum_rd_en/addr           psum SRAM read (1-cycle latency)
//   psum_wr_en/addr           psum SRAM write of the adder result
//   busy, done                pass status
//   dbg_state                 current FSM state
module adder_acc_sched
  import adder_acc_sched_pkg::*;
#(
  parameter int GROUP_W = 8,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [GROUP_W-1:0] cfg_groups,
  input  logic [ADDR_W-1:0]  cfg_pixels,
  input  logic               pe_valid,
  output logic               pe_ready,
  input  logic               out_ready,
  output logic               s1_en,
  output logic [1:0]         adder_mode,
  output logic               psum_zero,
  output logic               psum_rd_en,
  output logic [ADDR_W-1:0]  psum_rd_addr,
  output logic               psum_wr_en,
  output logic [ADDR_W-1:0]  psum_wr_addr,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  localparam logic [GROUP_W-1:0] ONE_G = GROUP_W'(1);

  state_e state_q, state_d;

  logic [GROUP_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0]  np_q, np_d;

  // Stage-1 register: what the adder does on the cycle after acceptance
  logic              s1_valid_q, s1_valid_d;
  logic [1:0]        s1_mode_q, s1_mode_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              s1_final_q, s1_final_d;
  logic              s1_zero_q, s1_zero_d;

  logic [GROUP_W-1:0] g;
  logic [ADDR_W-1:0]  p;
  logic               last_g;
  logic               last_beat;

  logic start_ok;
  logic stall_out;
  logic raw_haz;
  logic accept;

  assign start_ok = (state_q == ST_IDLE) & start;

  // A final beat waiting on downstream freezes the whole pipe.
  assign stall_out = s1_valid_q & s1_final_q & ~out_ready;

  // Only reachable with P==1: the next read would hit the address stage 1
  // is about to write. No bypass, so hold the PE for one cycle.
  assign raw_haz = s1_valid_q & ~s1_final_q & (g != '0) & (s1_addr_q == p);

  assign pe_ready = (state_q == ST_RUN) & ~stall_out & ~raw_haz;
  assign accept   = pe_valid & pe_ready;

  adder_acc_sched_acc_loop_cnt #(
    .GROUP_W (GROUP_W),
    .ADDR_W  (ADDR_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_ok),
    .adv_i       (accept),
    .groups_i    (n_q),
    .pixels_i    (np_q),
    .g_o         (g),
    .p_o         (p),
    .last_g_o    (last_g),
    .last_beat_o (last_beat)
  );

  // FSM next state and status outputs
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    np_d    = np_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d  = cfg_groups;
          np_d = cfg_pixels;
          if ((cfg_groups == '0) || (cfg_pixels == '0)) state_d = ST_DONE;
          else                                          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (accept && last_beat) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!s1_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage-1 load / retire
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_addr_d  = s1_addr_q;
    s1_final_d = s1_final_q;
    s1_zero_d  = s1_zero_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = p;
      s1_zero_d  = 1'b0;
      s1_final_d = 1'b0;
      if (n_q == ONE_G) begin
        // single group: no stored psum to add
        s1_mode_d  = MODE_BIAS;
        s1_zero_d  = 1'b1;
        s1_final_d = 1'b1;
      end else if (g == '0) begin
        s1_mode_d  = MODE_SUM;
      end else if (last_g) begin
        s1_mode_d  = MODE_BIAS;
        s1_final_d = 1'b1;
      end else begin
        s1_mode_d  = MODE_PSUM;
      end
    end else if (s1_valid_q && !stall_out) begin
      s1_valid_d = 1'b0;  // mode/zero/addr keep their last value
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      np_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_SUM;
      s1_addr_q  <= '0;
      s1_final_q <= 1'b0;
      s1_zero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      np_q       <= np_d;
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_addr_q  <= s1_addr_d;
      s1_final_q <= s1_final_d;
      s1_zero_q  <= s1_zero_d;
    end
  end

  assign s1_en        = accept;
  assign psum_rd_en   = accept & (g != '0);
  assign psum_rd_addr = p;
  assign psum_wr_en   = s1_valid_q & ~s1_final_q;
  assign psum_wr_addr = s1_addr_q;
  assign out_valid    = s1_valid_q & s1_final_q;
  assign adder_mode   = s1_mode_q;
  assign psum_zero    = s1_zero_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_adder_acc_sched.sv
// Testbench for adder_acc_sched: a negedge monitor keeps a reference model
// of the g/p schedule, pushes the expected stage-1 beat on every accept and
// pops/compares it when the DUT writes psum or hands off a final result.
module tb_adder_acc_sched;

  localparam int GW = 8;
  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          start;
  logic [GW-1:0] cfg_groups;
  logic [AW-1:0] cfg_pixels;
  logic          pe_valid;
  logic          pe_ready;
  logic          out_ready;
  logic          s1_en;
  logic [1:0]    adder_mode;
  logic          psum_zero;
  logic          psum_rd_en;
  logic [AW-1:0] psum_rd_addr;
  logic          psum_wr_en;
  logic [AW-1:0] psum_wr_addr;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  adder_acc_sched #(.GROUP_W(GW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_groups   (cfg_groups),
    .cfg_pixels   (cfg_pixels),
    .pe_valid     (pe_valid),
    .pe_ready     (pe_ready),
    .out_ready    (out_ready),
    .s1_en        (s1_en),
    .adder_mode   (adder_mode),
    .psum_zero    (psum_zero),
    .psum_rd_en   (psum_rd_en),
    .psum_rd_addr (psum_rd_addr),
    .psum_wr_en   (psum_wr_en),
    .psum_wr_addr (psum_wr_addr),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // expected stage-1 beat: {mode[1:0], psum_zero, wr_en, out_valid, addr}
  logic [AW+4:0] exp_q[$];
  int            acc_cyc_q[$];
  int            cyc = 0;
  bit            m_active = 0;
  int            m_left = 0;
  logic [GW-1:0] m_n = '0, m_g = '0;
  logic [AW-1:0] m_pp = '0, m_p = '0;
  int acc_total = 0, wr_total = 0, ov_total = 0, stall_total = 0;
  int strobe_total = 0, busy_total = 0, done_total = 0, last_done_cyc = 0;

  always @(negedge clk) begin : monitor
    logic [AW+4:0] obs;
    logic [AW+4:0] e;
    logic          exp_rdy;
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_active = 0;
      m_left   = 0;
    end else begin
      chk("busy", busy, m_active);
      exp_rdy = (m_left > 0) && !(out_valid && !out_ready) &&
                !(psum_wr_en && (m_g != 0) && (psum_wr_addr == m_p));
      chk("pe_ready", pe_ready, exp_rdy);

      // stage 1 outputs
      if (psum_wr_en || out_valid) begin
        obs = {adder_mode, psum_zero, psum_wr_en, out_valid, psum_wr_addr};
        if (exp_q.size() == 0) chk("spurious_out", 32'(obs), 0);
        else begin
          chk("stage1", 32'(obs), 32'(exp_q[0]));
          if (psum_wr_en || out_ready) void'(exp_q.pop_front());
        end
        if (psum_wr_en) wr_total++;
        if (out_valid && out_ready) ov_total++;
        if (out_valid && !out_ready) stall_total++;
      end

      // stage 0 accept
      if (pe_valid && pe_ready) begin
        chk("s1_en", s1_en, 1);
        chk("rd_en", psum_rd_en, (m_g != 0));
        if (m_g != 0) begin
          chk("rd_addr", psum_rd_addr, m_p);
          chk("raw", (psum_wr_en && (psum_wr_addr == psum_rd_addr)), 0);
        end
        if (m_n == 1)            e = {2'd2, 1'b1, 1'b0, 1'b1, m_p};
        else if (m_g == 0)       e = {2'd0, 1'b0, 1'b1, 1'b0, m_p};
        else if (m_g == m_n - 1) e = {2'd2, 1'b0, 1'b0, 1'b1, m_p};
        else                     e = {2'd1, 1'b0, 1'b1, 1'b0, m_p};
        exp_q.push_back(e);
        acc_total++;
        acc_cyc_q.push_back(cyc);
        m_left--;
        if (m_p == m_pp - 1) begin
          m_p = '0;
          m_g = m_g + 1;
        end else begin
          m_p = m_p + 1;
        end
      end else begin
        chk("no_s0", {s1_en, psum_rd_en}, 0);
      end

      if (s1_en || psum_rd_en || psum_wr_en || out_valid) strobe_total++;
      if (busy) busy_total++;
      if (start && !m_active) begin
        m_active = 1;
        m_n  = cfg_groups;
        m_pp = cfg_pixels;
        m_g  = '0;
        m_p  = '0;
        m_left = int'(cfg_groups) * int'(cfg_pixels);
      end
      if (done) begin
        done_total++;
        last_done_cyc = cyc;
        m_active = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  int pass_a0, pass_b0, pass_s0, pass_st0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 = pe_valid always 1, 1 = random
  // rmode: 0 = out_ready always 1, 1 = random, 2 = hold off the first final beat 3 cycles
  // again: pulse start with a different config while the pass runs
  task automatic run_pass(input int n, input int p, input int vmode, input int rmode,
                          input bit again);
    int d0, w0, o0, stall_left, exp_w, exp_o;
    d0 = done_total;  w0 = wr_total;  o0 = ov_total;
    pass_a0 = acc_total; pass_b0 = busy_total; pass_s0 = strobe_total;
    pass_st0 = stall_total;
    stall_left = 3;
    cfg_groups = GW'(n);
    cfg_pixels = AW'(p);
    pe_valid   = (vmode == 0);
    out_ready  = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4000 && done_total == d0; i++) begin
      pe_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (rmode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
      if (again && i == 2) begin
        cfg_groups = GW'(1);
        cfg_pixels = AW'(1);
        start = 1'b1;
      end else start = 1'b0;
      step();
    end
    start = 1'b0;
    pe_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    exp_o = (n == 0 || p == 0) ? 0 : p;
    exp_w = (n <= 1 || p == 0) ? 0 : (n - 1) * p;
    chk("done_count", done_total - d0, 1);
    chk("beats", acc_total - pass_a0, n * p);
    chk("writes", wr_total - w0, exp_w);
    chk("outs", ov_total - o0, exp_o);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_groups = '0;
    cfg_pixels = '0;
    pe_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("reset_outs", {pe_ready, s1_en, adder_mode, psum_zero, psum_rd_en, psum_rd_addr,
                       psum_wr_en, psum_wr_addr, out_valid, busy, done}, 0);
    rst = 1'b0;
    step();

    // single group: bias mode with zeroed psum, done 6 cycles after first accept
    run_pass(1, 4, 0, 0, 0);
    chk("done_latency", last_done_cyc - acc_cyc_q[pass_a0], 6);

    // three groups, with an ignored start mid-run
    run_pass(3, 2, 0, 0, 1);

    // P==1: second beat held one cycle behind the pending write
    run_pass(2, 1, 0, 0, 0);
    chk("raw_gap", acc_cyc_q[pass_a0 + 1] - acc_cyc_q[pass_a0], 2);

    // downstream backpressure on the first final beat
    run_pass(2, 3, 0, 2, 0);
    chk("stall_cycles", stall_total - pass_st0, 3);

    // empty passes
    run_pass(0, 5, 0, 0, 0);
    chk("n0_busy", busy_total - pass_b0, 1);
    chk("n0_strobes", strobe_total - pass_s0, 0);
    run_pass(3, 0, 0, 0, 0);
    chk("p0_busy", busy_total - pass_b0, 1);

    // random handshakes
    run_pass(3, 4, 1, 1, 0);
    run_pass(5, 3, 1, 1, 0);

    // asynchronous reset in the middle of group 2
    begin
      int a0;
      a0 = acc_total;
      cfg_groups = GW'(4);
      cfg_pixels = AW'(5);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 500 && (acc_total - a0) < 10; i++) begin
        pe_valid = 1'($urandom_range(0, 1));
        step();
      end
      chk("mid_group", acc_total - a0, 10);
      rst = 1'b1;
      #1;
      chk("midrun_reset_outs", {pe_ready, s1_en, adder_mode, psum_zero, psum_rd_en, psum_rd_addr,
                                psum_wr_en, psum_wr_addr, out_valid, busy, done}, 0);
      step();
      pe_valid = 1'b0;
      rst = 1'b0;
      step();
    end
    run_pass(4, 5, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_acc_sched.md
Name: adder_acc_sched

Overview:
Sequences the three-input accumulation adder across input-channel groups for one convolution layer pass. For every output pixel it picks the adder mode:
- first group: plain sum, written to the psum buffer;
- middle groups: sum plus psum, written back;
- last group: sum plus psum plus bias, emitted downstream.

It sits between the PE row-sum producers, the psum SRAM (synchronous read, 1-cycle latency) and the output writer. It drives a 2-stage datapath enable and handshakes on both sides.

Parameters:
GROUP_W, 8, width of channel-group count
ADDR_W, 10, psum buffer address width / pixel count width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latches cfg_* and begins a pass (IDLE only)
cfg_groups  in  GROUP_W  number of channel groups N
cfg_pixels  in  ADDR_W  output pixels per group P
pe_valid  in  1  PE row sums (Data_in1..3) valid this cycle
pe_ready  out  1  scheduler accepts beat; accept = pe_valid & pe_ready
out_ready  in  1  downstream can take final result
s1_en  out  1  datapath stage-1 register enable (captures PE sums)
adder_mode  out  2  Mode to adder: 0 sum, 1 +psum, 2 +psum+bias
psum_zero  out  1  forces adder Psum input to 0
psum_rd_en  out  1  psum SRAM read strobe
psum_rd_addr  out  ADDR_W  read address
psum_wr_en  out  1  psum SRAM write strobe (data = adder Result)
psum_wr_addr  out  ADDR_W  write address
out_valid  out  1  final (biased) result valid to downstream
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (async, any state): FSM=IDLE; counters g,p=0; stage-1 valid=0; all outputs 0; adder_mode=0.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE + start: latch N, P; busy=1. If N==0 or P==0, go to DONE; otherwise go to RUN.
  - RUN: on each accept, advance p. When p wraps from P-1 to 0, g increments. Accept at (g=N-1, p=P-1) -> DRAIN.
  - DRAIN: wait until stage-1 retires -> DONE.
  - DONE: done=1 for one cycle, busy=0 on exit, return to IDLE.
  - start outside IDLE is ignored.
- Stage 0, accept cycle t:
  - s1_en=1.
  - psum_rd_en=1 with psum_rd_addr=p when g>0 (combinational on accept; address from registered p).
  - Stage-1 register loads {mode, addr=p, final flag, zero flag}.
- Stage 1, cycle t+1 (adder inputs valid, SRAM data valid):
  - N==1: mode 2, psum_zero=1, final.
  - g==0, N>1: mode 0, psum_wr_en, psum_wr_addr=p.
  - 0<g<N-1: mode 1, psum_wr_en.
  - g==N-1, N>1: mode 2, out_valid, no write.
- adder_mode and psum_zero come from the stage-1 register. They hold their last value when stage 1 is empty; psum_wr_en and out_valid are 0 then.
- Output backpressure: when stage 1 holds a final beat and out_ready=0:
  - stage 1 holds;
  - pe_ready=0, s1_en=0, psum_rd_en=0;
  - out_valid stays 1 with stable mode and address.
- Retire when out_ready=1.
- Read-after-write hazard: if stage 1 holds a write to address A and the next read address equals A (only possible with P==1), drop pe_ready for that cycle. There is no bypass.
- pe_ready=1 in RUN unless stalled by either rule above; pe_ready=0 in IDLE, DRAIN and DONE.
- Counter widths exactly GROUP_W/ADDR_W. P=2^ADDR_W-1 is supported; the wrap compares against P-1, not overflow.
- Width and arithmetic rules belong to the adder; the scheduler adds no arithmetic.

Decomposition:
- Shared package/def: mode encodings MODE_SUM=0, MODE_PSUM=1, MODE_BIAS=2, and the FSM state encoding.
- One natural sub-module, acc_loop_cnt: the nested g/p counter with wrap and last-beat flags.

Test Plan:
- N=1, P=4, pe_valid constant, out_ready=1 -> 4 beats with mode 2, psum_zero=1, out_valid on t+1, no psum_wr_en; done 6 cycles after first accept.
- N=3, P=2 -> modes: 0 (g0), 1 (g1), 2 (g2). Writes to addr 0,1 in g0 and g1; reads to addr 0,1 in g1 and g2; out_valid twice; done pulse once.
- N=2, P=1 -> second accept delayed one cycle (pe_ready=0 while write to addr 0 is pending); read of addr 0 occurs after the write.
- N=2, P=3 with out_ready=0 for 3 cycles on the first final beat -> out_valid, adder_mode=2 and address held; pe_ready=0 and no extra reads; resumes without loss.
- start with N=0 -> busy for 1 cycle, done pulse, no strobes. start during RUN -> ignored.
- Assert rst mid-RUN (N=4, P=5, g=2) -> all outputs 0 immediately; a fresh start then runs the full pass correctly from g=0.
